// File: rtl/dot_pkg.sv
// Shared constants for the dot-product accumulator pipeline.
//   LANES_DEF : default number of parallel data/weight lanes
//   DW_DEF    : default signed element width
//   AW_DEF    : default signed accumulator/result width
//   sum_width : width of the lane-sum tree. It is wide enough that the sum
//               of LANES full-precision products can never overflow.
package dot_pkg;

  localparam int LANES_DEF = 9;
  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 32;

  function automatic int sum_width(input int lanes, input int dw);
    return 2 * dw + $clog2(lanes);
  endfunction

endpackage

// File: rtl/dot_mul_lanes.sv
// Parallel signed multipliers, purely combinational.
//   data   : LANES packed signed elements, lane i at [i*DW +: DW]
//   weight : LANES packed signed elements, same packing
//   prod   : LANES packed full-precision signed products, lane i at [i*2*DW +: 2*DW]
module dot_mul_lanes
  import dot_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic [LANES*DW-1:0]   data,
  input  logic [LANES*DW-1:0]   weight,
  output logic [LANES*2*DW-1:0] prod
);

  localparam int PW = 2 * DW;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] w;
    logic signed [PW-1:0] p;

    assign d = data[i*DW +: DW];
    assign w = weight[i*DW +: DW];
    // Both operands are sign-extended to the product width, so the product is exact.
    assign p = PW'(d) * PW'(w);
    assign prod[i*PW +: PW] = p;
  end

endmodule

// File: rtl/dot_acc_pipe.sv
// Pipelined signed dot-product with a saturating group accumulator.
// The pipeline has three register stages:
//   S1 registers the lane products.
//   S2 registers the lane-sum tree output.
//   S3 does the accumulate and saturate step and loads the output.
// A single advance enable stalls every stage at once while a result waits
// for the downstream side.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake
//   in_data/in_weight   : LANES packed signed elements of width DW
//   in_last             : final beat of an accumulation group
//   out_valid/out_ready : result handshake
//   out_sum             : saturated group dot-product
//   out_sat             : saturation occurred somewhere in the group
module dot_acc_pipe
  import dot_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*DW-1:0]  in_data,
  input  logic [LANES*DW-1:0]  in_weight,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_sum,
  output logic                 out_sat
);

  localparam int PW  = 2 * DW;
  localparam int SW  = sum_width(LANES, DW);
  localparam int AW1 = AW + 1;

  function automatic logic sat_ovf(input logic signed [AW:0] v);
    return v[AW] != v[AW-1];
  endfunction

  function automatic logic signed [AW-1:0] sat_clamp(input logic signed [AW:0] v);
    if (!sat_ovf(v)) return v[AW-1:0];
    return v[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  endfunction

  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  logic [LANES*PW-1:0] prod;

  dot_mul_lanes #(.LANES(LANES), .DW(DW)) u_mul (
    .data   (in_data),
    .weight (in_weight),
    .prod   (prod)
  );

  // ---- S1: registered lane products ----
  logic [LANES*PW-1:0] prod_p1;
  logic                vld_p1;
  logic                last_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (en) begin
      vld_p1  <= accept;
      last_p1 <= accept && in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) prod_p1 <= prod;
  end

  // ---- S2: registered lane sum ----
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_p2;
  logic                 vld_p2;
  logic                 last_p2;

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SW'($signed(prod_p1[i*PW +: PW]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (en && vld_p1) sum_p2 <= sum;
  end

  // ---- S3: saturating accumulate and result load ----
  // The accumulator is zeroed by reset and at every group end. A group's
  // first beat therefore always adds to 0 without a separate first flag.
  logic signed [AW-1:0] acc;
  logic                 sticky;
  logic signed [AW:0]   tot;
  logic                 ovf;
  logic signed [AW-1:0] res;

  always_comb begin
    tot = AW1'(acc) + AW1'(sum_p2);
    ovf = sat_ovf(tot);
    res = sat_clamp(tot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      // When en is high, any held result is being handed off this cycle.
      out_valid <= vld_p2 && last_p2;
      if (vld_p2) begin
        if (last_p2) begin
          out_sum <= res;
          out_sat <= sticky || ovf;
          acc     <= '0;
          sticky  <= 1'b0;
        end else begin
          acc     <= res;
          sticky  <= sticky || ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_acc_pipe.sv
module tb_dot_acc_pipe;

  localparam int LANES = 9;
  localparam int DW    = 8;
  localparam int W     = LANES * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_ready = 1'b1;
  logic [W-1:0]         in_data = '0;
  logic [W-1:0]         in_weight = '0;
  logic                 rdy32, rdy20, ov32, ov20, sat32, sat20;
  logic signed [31:0]   sum32;
  logic signed [19:0]   sum20;

  dot_acc_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .out_valid(ov32), .out_ready(out_ready), .out_sum(sum32), .out_sat(sat32)
  );

  dot_acc_pipe #(.AW(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy20),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .out_valid(ov20), .out_ready(out_ready), .out_sum(sum20), .out_sat(sat20)
  );

  int checks = 0;
  int failures = 0;
  longint q32_sum[$];
  bit     q32_sat[$];
  longint q20_sum[$];
  bit     q20_sat[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] all_lanes(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] lane0(input int v);
    logic [W-1:0] r;
    r = '0;
    r[DW-1:0] = v[DW-1:0];
    return r;
  endfunction

  task automatic expect_res(input longint s32, input bit t32, input longint s20, input bit t20);
    q32_sum.push_back(s32);
    q32_sat.push_back(t32);
    q20_sum.push_back(s20);
    q20_sat.push_back(t20);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] w, input logic l);
    int n;
    in_data   = d;
    in_weight = w;
    in_last   = l;
    in_valid  = 1'b1;
    #1;
    n = 0;
    while (!rdy32 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard monitor: pops on every output handshake and checks the
  // held output for stability while backpressured.
  longint es, prev32, prev20;
  bit     et, prevs32, prevs20;
  bit     hold32 = 1'b0;
  bit     hold20 = 1'b0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      hold32 = 1'b0;
      hold20 = 1'b0;
    end else begin
      if (hold32) begin
        chk("hold_sum32", sum32, prev32);
        chk("hold_sat32", sat32, prevs32);
      end
      if (hold20) begin
        chk("hold_sum20", sum20, prev20);
        chk("hold_sat20", sat20, prevs20);
      end
      if (ov32 && out_ready) begin
        if (q32_sum.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result32: got %0d, expected no result", sum32);
        end else begin
          es = q32_sum.pop_front();
          et = q32_sat.pop_front();
          chk("sum32", sum32, es);
          chk("sat32", sat32, et);
        end
      end
      if (ov20 && out_ready) begin
        if (q20_sum.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result20: got %0d, expected no result", sum20);
        end else begin
          es = q20_sum.pop_front();
          et = q20_sat.pop_front();
          chk("sum20", sum20, es);
          chk("sat20", sat20, et);
        end
      end
      hold32  = ov32 && !out_ready;
      hold20  = ov20 && !out_ready;
      prev32  = sum32;
      prevs32 = sat32;
      prev20  = sum20;
      prevs20 = sat20;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid32", ov32, 0);
    chk("rst_out_sum32", sum32, 0);
    chk("rst_out_sat32", sat32, 0);
    chk("rst_in_ready32", rdy32, 1);
    chk("rst_out_valid20", ov20, 0);
    chk("rst_out_sum20", sum20, 0);
    chk("rst_out_sat20", sat20, 0);
    chk("rst_in_ready20", rdy20, 1);

    // One-beat group: 9 * (3 * -2) = -54, result 3 cycles after acceptance.
    @(negedge clk);
    expect_res(-54, 0, -54, 0);
    send(all_lanes(3), all_lanes(-2), 1'b1);
    #1;
    chk("lat_cycle1", ov32, 0);
    @(negedge clk);
    #1;
    chk("lat_cycle2", ov32, 0);
    @(negedge clk);
    #1;
    chk("lat_cycle3_32", ov32, 1);
    chk("lat_cycle3_20", ov20, 1);

    // Back-to-back 3-beat group on lane0: 100 - 20 - 16256.
    @(negedge clk);
    expect_res(-16176, 0, -16176, 0);
    send(lane0(10), lane0(10), 1'b0);
    send(lane0(-5), lane0(4), 1'b0);
    send(lane0(127), lane0(-128), 1'b1);

    // 4 beats of 9 * 16384 = 589824: clamps to 524287 only at AW=20.
    expect_res(589824, 0, 524287, 1);
    for (int i = 0; i < 4; i++) send(all_lanes(-128), all_lanes(-128), (i == 3));
    expect_res(1, 0, 1, 0);
    send(lane0(1), lane0(1), 1'b1);

    // Backpressure: hold out_ready low while results are pending.
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        expect_res(9, 0, 9, 0);
        send(all_lanes(1), all_lanes(1), 1'b1);
        expect_res(18, 0, 18, 0);
        send(all_lanes(2), all_lanes(3), 1'b0);
        send(all_lanes(-1), all_lanes(4), 1'b1);
        expect_res(10000, 0, 10000, 0);
        send(lane0(100), lane0(100), 1'b1);
      end
      begin
        #1;
        n = 0;
        while (!ov32 && n < 50) begin
          @(negedge clk);
          #1;
          n++;
        end
        if (n >= 50) begin
          checks++;
          failures++;
          $display("FAIL bp_wait: out_valid never rose within %0d cycles", n);
        end
        repeat (5) begin
          chk("stall_in_ready32", rdy32, 0);
          chk("stall_in_ready20", rdy20, 0);
          @(negedge clk);
          #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join

    // Reset in the middle of a group discards the partial sum.
    repeat (8) @(negedge clk);
    send(all_lanes(5), all_lanes(5), 1'b0);
    send(all_lanes(5), all_lanes(5), 1'b0);
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov32, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_res(36, 0, 36, 0);
    send(all_lanes(2), all_lanes(2), 1'b1);

    n = 0;
    while ((q32_sum.size() != 0 || q20_sum.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    chk("pending_results", q32_sum.size() + q20_sum.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_acc_pipe.md
DOT_ACC_PIPE -- requirements
Module: dot_acc_pipe

Interface
REQ-001 SHALL have parameter LANES, default 9, number of parallel data/weight lanes (1..32).
REQ-002 SHALL have parameter DW, default 8, signed width of each data and weight element.
REQ-003 SHALL have parameter AW, default 32, signed accumulator/result width; AW >= 2*DW+clog2(LANES) is required.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, input beat valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a beat.
REQ-008 SHALL have port in_data, input, LANES*DW, signed data, lane i at bits [i*DW +: DW].
REQ-009 SHALL have port in_weight, input, LANES*DW, signed weights, same packing as in_data.
REQ-010 SHALL have port in_last, input, 1, marks the final beat of an accumulation group.
REQ-011 SHALL have port out_valid, output, 1, group result valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have port out_sum, output, AW, signed saturated group dot-product.
REQ-014 SHALL have port out_sat, output, 1, set if any saturation occurred within the group.

Function
REQ-015 SHALL accept a beat at a rising edge only when in_valid and in_ready are both 1.
REQ-016 SHALL form lane products data_i*weight_i as full signed 2*DW-bit values, registered in stage 1 (S1).
REQ-017 SHALL sum all LANES products in stage 2 (S2) at width 2*DW+clog2(LANES), with no overflow possible.
REQ-018 SHALL add the S2 sum in stage 3 (S3) to the accumulator sign-extended to AW; if the group's first beat, SHALL add it to 0 instead.
REQ-019 SHALL clamp each S3 result to [-2^(AW-1), 2^(AW-1)-1] and set a sticky group-saturation flag when clamping occurs.
REQ-020 SHALL, when the S3 beat carries last, load out_sum/out_sat with the clamped result and flag, set out_valid, and clear accumulator and flag for the next group.
REQ-021 SHALL present a result with out_valid asserted 3 cycles after the in_last beat is accepted, when no stall occurs.
REQ-022 SHALL sustain one beat per cycle throughput while out_valid is 0 or out_ready is 1.
REQ-023 SHALL stall globally: advance enable = !out_valid | out_ready; in_ready SHALL equal this enable; when stalled, S1/S2/S3, accumulator and outputs SHALL hold.
REQ-024 SHALL hold out_sum and out_sat stable while out_valid=1 and out_ready=0.
REQ-025 SHALL clear out_valid on handshake unless a new last-beat result loads in the same cycle, in which case out_valid SHALL stay 1 with the new values.
REQ-026 SHALL treat a single beat with in_last=1 as a complete one-beat group.
REQ-027 SHALL ignore in_data, in_weight and in_last when no beat is accepted; bubbles SHALL NOT alter the accumulator.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear S1/S2 valid bits, accumulator, sticky flag, out_valid, out_sum and out_sat to 0, with in_ready 1 from the first edge after reset release.
REQ-029 SHALL discard any partially accumulated group on reset mid-operation; the first beat after reset SHALL start a new group.

Structure
REQ-030 SHALL take LANES, DW, AW defaults and the derived sum-width constant from shared package dot_pkg.
REQ-031 SHALL instantiate one sub-module, dot_mul_lanes, holding the LANES parallel signed multipliers (combinational); pipeline, tree and accumulator SHALL stay in dot_acc_pipe.

Verification
REQ-032 SHALL cover a one-beat group: all data=3, all weights=-2, in_last=1 -> out_sum=-54, out_sat=0, out_valid exactly 3 cycles after acceptance.
REQ-033 SHALL cover a 3-beat group of back-to-back beats with lane0 only, (data,weight) = (10,10),(-5,4),(127,-128) -> out_sum=100-20-16256=-16176.
REQ-034 SHALL cover saturation with AW=20: 4 beats all data=-128, weights=-128 -> out_sum=524287, out_sat=1; following group 1*1 on lane0 -> out_sum=1, out_sat=0.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles with result pending -> in_ready=0, out_sum stable, no beat lost; streaming groups resume with correct sums after release.
REQ-036 SHALL cover reset mid-group: two beats without last, rst_n pulse, then a one-beat group data=weight=2 on all 9 lanes -> out_sum=36.
